// File: rtl/button_conditioner.sv
// Synchronises and debounces four raw buttons into the pause, lap, clear and view controls for the stopwatch.
// Latency is DEBOUNCE_CYCLES+3 cycles from a raw edge to an output change. There is no backpressure: outputs are free-running registered levels and pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STRETCH_CYCLES  = 600000
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic btn_pause,
  input  logic btn_lap,
  input  logic btn_view,
  input  logic btn_clear,
  output logic pause,
  output logic lap,
  output logic clear,
  output logic lap1,
  output logic lap2,
  output logic lap3
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STR_LAST = SW'(STRETCH_CYCLES - 1);

  localparam int B_PAUSE = 0;
  localparam int B_LAP   = 1;
  localparam int B_VIEW  = 2;
  localparam int B_CLEAR = 3;

  typedef enum logic [2:0] {
    V_LIVE = 3'b000,
    V_L1   = 3'b100,
    V_L2   = 3'b010,
    V_L3   = 3'b001
  } view_e;

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    press_q, press_d;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];

  logic          pause_q, pause_d;
  logic          lap_q, lap_d;
  logic          clear_q, clear_d;
  logic [SW-1:0] lap_cnt_q, lap_cnt_d;
  logic [SW-1:0] clr_cnt_q, clr_cnt_d;
  view_e         view_q, view_d;

  assign raw = {btn_clear, btn_view, btn_lap, btn_pause};

  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) stable_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
      // Strobe registered alongside the stable update so it lines up with the new level
      press_d[i] = stable_d[i] & ~stable_q[i];
    end
  end

  always_comb begin
    pause_d   = pause_q;
    lap_d     = lap_q;
    clear_d   = clear_q;
    lap_cnt_d = lap_cnt_q;
    clr_cnt_d = clr_cnt_q;
    view_d    = view_q;

    if (lap_q) begin
      if (lap_cnt_q == '0) lap_d = 1'b0;
      else                 lap_cnt_d = lap_cnt_q - SW'(1);
    end
    if (clear_q) begin
      if (clr_cnt_q == '0) clear_d = 1'b0;
      else                 clr_cnt_d = clr_cnt_q - SW'(1);
    end

    if (press_q[B_CLEAR]) begin
      pause_d   = 1'b1;
      view_d    = V_LIVE;
      lap_d     = 1'b0;
      lap_cnt_d = '0;
      if (!clear_q) begin
        clear_d   = 1'b1;
        clr_cnt_d = STR_LAST;
      end
    end else begin
      if (press_q[B_PAUSE]) pause_d = ~pause_q;
      if (press_q[B_LAP] && !lap_q) begin
        lap_d     = 1'b1;
        lap_cnt_d = STR_LAST;
      end
      if (press_q[B_VIEW]) begin
        unique case (view_q)
          V_LIVE:  view_d = V_L1;
          V_L1:    view_d = V_L2;
          V_L2:    view_d = V_L3;
          default: view_d = V_LIVE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      pause_q   <= 1'b1;
      lap_q     <= 1'b0;
      clear_q   <= 1'b0;
      lap_cnt_q <= '0;
      clr_cnt_q <= '0;
      view_q    <= V_LIVE;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      pause_q   <= pause_d;
      lap_q     <= lap_d;
      clear_q   <= clear_d;
      lap_cnt_q <= lap_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      view_q    <= view_d;
    end
  end

  assign pause = pause_q;
  assign lap   = lap_q;
  assign clear = clear_q;
  assign lap1  = view_q[2];
  assign lap2  = view_q[1];
  assign lap3  = view_q[0];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and STRETCH_CYCLES=3.
// Expected output vectors are {pause,lap,clear,lap1,lap2,lap3}; button vectors are {clear,view,lap,pause}.
module tb_button_conditioner;

  logic clk_50M = 1'b0;
  logic reset = 1'b0;
  logic btn_pause = 1'b0, btn_lap = 1'b0, btn_view = 1'b0, btn_clear = 1'b0;
  logic pause, lap, clear, lap1, lap2, lap3;

  int checks = 0;
  int failures = 0;

  always #5 clk_50M = ~clk_50M;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(3)) dut (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .btn_pause(btn_pause),
    .btn_lap  (btn_lap),
    .btn_view (btn_view),
    .btn_clear(btn_clear),
    .pause    (pause),
    .lap      (lap),
    .clear    (clear),
    .lap1     (lap1),
    .lap2     (lap2),
    .lap3     (lap3)
  );

  typedef struct {
    logic [3:0] btn;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {pause, lap, clear, lap1, lap2, lap3};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  // One cycle: advance, compare outputs and view exclusivity, then drive buttons for this cycle.
  task automatic step_chk(input string name, input logic [3:0] btn, input logic [5:0] exp);
    @(posedge clk_50M);
    #1;
    chk(name, exp);
    checks++;
    if ($countones({lap1, lap2, lap3}) > 1) begin
      failures++;
      $display("FAIL %s_onehot t=%0t got=%b want=at most one set", name, $time, {lap1, lap2, lap3});
    end
    {btn_clear, btn_view, btn_lap, btn_pause} = btn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0000, 100, 6'b100000};
    tbl[1]  = '{4'b0001,   7, 6'b100000};
    tbl[2]  = '{4'b0001,  13, 6'b000000};
    tbl[3]  = '{4'b0000,   9, 6'b000000};
    tbl[4]  = '{4'b0001,   7, 6'b000000};
    tbl[5]  = '{4'b0001,  40, 6'b100000};
    tbl[6]  = '{4'b0000,  10, 6'b100000};
    tbl[7]  = '{4'b0100,   5, 6'b100000};
    tbl[8]  = '{4'b0000,   2, 6'b100000};
    tbl[9]  = '{4'b0000,   8, 6'b100100};
    tbl[10] = '{4'b0100,   5, 6'b100100};
    tbl[11] = '{4'b0000,   2, 6'b100100};
    tbl[12] = '{4'b0000,   8, 6'b100010};
    tbl[13] = '{4'b0100,   5, 6'b100010};
    tbl[14] = '{4'b0000,   2, 6'b100010};
    tbl[15] = '{4'b0000,   8, 6'b100001};
    tbl[16] = '{4'b0100,   5, 6'b100001};
    tbl[17] = '{4'b0000,   2, 6'b100001};
    tbl[18] = '{4'b0000,   8, 6'b100000};
    tbl[19] = '{4'b0100,   5, 6'b100000};
    tbl[20] = '{4'b0000,   2, 6'b100000};
    tbl[21] = '{4'b0000,   8, 6'b100100};

    // Held in reset: outputs at reset values even with buttons wiggling
    repeat (3) @(posedge clk_50M);
    #1;
    chk("reset_state", 6'b100000);
    btn_pause = 1'b1;
    btn_clear = 1'b1;
    repeat (6) @(posedge clk_50M);
    #1;
    chk("reset_btn_ignored", 6'b100000);
    btn_pause = 1'b0;
    btn_clear = 1'b0;
    repeat (6) @(posedge clk_50M);
    #1;
    reset = 1'b1;

    // Idle, pause press/hold/re-press, then five view presses
    for (int r = 0; r < 22; r++)
      for (int k = 0; k < tbl[r].n; k++)
        step_chk($sformatf("tbl%0d", r), tbl[r].btn, tbl[r].exp);

    // Lap glitch train: never accepted
    for (int g = 0; g < 10; g++) begin
      for (int h = 0; h < 3; h++) step_chk("lap_glitch", 4'b0010, 6'b100100);
      step_chk("lap_glitch", 4'b0000, 6'b100100);
    end
    // Clean 10-cycle lap press: lap high exactly 7..9 cycles after the edge
    for (int i = 0; i < 20; i++)
      step_chk("lap_stretch", (i < 10) ? 4'b0010 : 4'b0000,
               (i >= 7 && i <= 9) ? 6'b110100 : 6'b100100);

    // Pause and view together: both honoured, giving pause=0 and view L2
    for (int i = 0; i < 15; i++)
      step_chk("pause_view_same", (i < 5) ? 4'b0101 : 4'b0000,
               (i < 7) ? 6'b100100 : 6'b000010);

    // Lap stretching, then clear+view on the next cycle: clear wins
    for (int i = 0; i < 25; i++) begin
      logic [3:0] b;
      logic [5:0] e;
      b = {(i >= 1 && i <= 5), (i >= 1 && i <= 5), (i <= 4), 1'b0};
      if (i < 7)        e = 6'b000010;
      else if (i == 7)  e = 6'b010010;
      else if (i <= 10) e = 6'b101000;
      else              e = 6'b100000;
      step_chk("clear_prio", b, e);
    end

    // Reset mid lap pulse and mid view debounce
    for (int i = 0; i < 9; i++)
      step_chk("pre_reset", {1'b0, (i >= 3), (i <= 4), 1'b0},
               (i >= 7) ? 6'b110000 : 6'b100000);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_async", 6'b100000);
    for (int i = 0; i < 3; i++) step_chk("in_reset", 4'b0100, 6'b100000);
    reset = 1'b1;
    // View held through reset: needs a full sync+debounce before the event
    for (int i = 1; i <= 12; i++)
      step_chk("post_reset_deb", 4'b0100, (i < 7) ? 6'b100000 : 6'b100100);
    for (int i = 0; i < 10; i++) step_chk("post_reset_rel", 4'b0000, 6'b100100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage for the stopwatch counter, driven by the board's raw push-buttons.
- Synchronises and debounces four buttons, then turns presses into the control signals the counter consumes:
  - pause level (toggle)
  - lap capture request, stretched long enough to be seen by the 100 Hz tick domain
  - one-hot lap view select
  - clear request
- Single clock domain (clk_50M); all outputs registered.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk_50M cycles needed to accept a level change (10 ms); minimum 2.
- STRETCH_CYCLES, 600000, length in cycles of lap and clear pulses; must exceed one 100 Hz tick period (500000); minimum 1.

Ports:
- clk_50M  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_pause  in  1  raw pause button, active-high, asynchronous to clk_50M.
- btn_lap  in  1  raw lap button, active-high, asynchronous.
- btn_view  in  1  raw view-cycle button, active-high, asynchronous.
- btn_clear  in  1  raw clear button, active-high, asynchronous.
- pause  out  1  1 = counting halted; toggles on each pause press.
- lap  out  1  lap capture request, high for exactly STRETCH_CYCLES cycles per press.
- clear  out  1  clear request, high for exactly STRETCH_CYCLES cycles per press.
- lap1  out  1  view select lap 1 (one-hot with lap2/lap3, all 0 = live view).
- lap2  out  1  view select lap 2.
- lap3  out  1  view select lap 3.

Behaviour:
- Reset (reset=0, async):
  - pause=1; lap=0, clear=0, lap1=lap2=lap3=0.
  - Sync flops, stable levels and all counters cleared to 0.
- Per-button synchroniser: 2 flops; sync output = raw delayed 2 cycles.
- Per-button debounce:
  - Counter width clog2(DEBOUNCE_CYCLES).
  - sync == stable: counter cleared to 0.
  - sync != stable: counter increments; when it reaches DEBOUNCE_CYCLES-1 and mismatch persists, stable <= sync and counter cleared.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count and is never seen.
- Press event: one-cycle internal strobe on stable 0->1. Release (1->0) produces no event.
- Latency: a clean raw 0->1 edge at cycle T changes the affected output at cycle T+DEBOUNCE_CYCLES+3 exactly.
- Pause: press toggles pause. Level is held indefinitely.
- Lap/clear stretch:
  - A press loads a down-counter; output is high for exactly STRETCH_CYCLES consecutive cycles.
  - A press arriving while already stretching is ignored; no extension, no restart.
- View FSM, states LIVE(000), L1(100), L2(010), L3(001) on {lap1,lap2,lap3}:
  - Each view press advances LIVE->L1->L2->L3->LIVE, wrapping after L3.
  - Outputs always one-hot or all-zero; never two set.
- Clear press:
  - Starts the clear pulse, forces view to LIVE and pause to 1.
  - Aborts any in-progress lap stretch: lap=0 next cycle.
- Simultaneous events in the same cycle:
  - clear has priority over pause, view and lap: those events are discarded.
  - pause, view and lap events together are all honoured independently.
- Button held down: exactly one event per press; no auto-repeat.
- Reset mid-operation: all state returns to reset values immediately (async); stretch and debounce counts are lost.
- Outputs depend only on registers; no combinational path from btn_* to outputs.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, STRETCH_CYCLES=3.)
1. Reset release, no buttons -> pause=1, lap=clear=0, {lap1,lap2,lap3}=000 held for 100 cycles.
2. btn_pause raised at cycle 10 and held 20 cycles -> pause falls to 0 at cycle 17 exactly. Second clean press -> pause back to 1. Holding the button -> no further toggles.
3. btn_lap glitch trains (high 3 cycles / low 1, repeated 10 times) then a clean 10-cycle press at cycle 50 -> lap=0 during the glitches; lap=1 for exactly cycles 57..59.
4. Five clean btn_view presses -> view sequence 100, 010, 001, 000, 100; one-hot checked every cycle.
5. View in L2, pause=0, lap stretching; btn_clear and btn_view pressed on the same cycle -> clear high 3 cycles, view=000, pause=1, lap drops next cycle, no view advance.
6. reset asserted mid lap pulse and mid debounce count -> all outputs at reset values in the same cycle. After release, a press needs a full 4-cycle debounce before any event.
